dot_product_unit: RTL and testbench

//  Streaming signed dot-product stage that consumes the operand stream produced by the

---
 rtl/dot_product_unit.sv | 120 ++++++++++++
 tb/tb_dot_product_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dot_product_unit.sv
// Streaming signed dot-product stage: one w/x pair per beat, one sum per row.
// Define DPU_SATURATE_EN for saturating adds with a sticky src_sat flag.
module dot_product_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                snk_vld,
  output logic                snk_rdy,
  input  logic [2*DATA_W-1:0] snk_data,
  input  logic                snk_last,
  output logic                src_vld,
  input  logic                src_rdy,
  output logic [ACC_W-1:0]    src_data,
  output logic [CNT_W-1:0]    src_cnt,
  output logic                src_sat,
  output logic                busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state;

  logic signed [DATA_W-1:0]   w;
  logic signed [DATA_W-1:0]   x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    sum_wrap;
  logic signed [ACC_W-1:0]    sum_next;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic                       first;
  logic                       accept;
  logic                       acc_load;
  logic                       res_load;

  assign w        = snk_data[DATA_W-1:0];
  assign x        = snk_data[2*DATA_W-1:DATA_W];
  assign prod     = w * x;
  assign prod_ext = ACC_W'(prod);

  assign snk_rdy  = !src_vld || src_rdy;
  assign accept   = snk_vld && snk_rdy;
  assign acc_load = accept && !snk_last;
  assign res_load = accept && snk_last;
  assign busy     = (state == ACCUM);
  assign first    = (state == IDLE);

  assign base     = first ? '0 : acc;
  assign sum_wrap = base + prod_ext;

  assign cnt_next = first ? CNT_W'(1)
                  : (&cnt) ? cnt
                  : cnt + 1'b1;

`ifdef DPU_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SUM_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf;
  logic sat_acc;
  logic sat_next;

  // Overflow only when both addends share a sign the sum lacks.
  assign ovf = (base[ACC_W-1] == prod_ext[ACC_W-1])
            && (sum_wrap[ACC_W-1] != base[ACC_W-1]);

  assign sum_next = !ovf ? sum_wrap
                  : base[ACC_W-1] ? SUM_MIN
                  : SUM_MAX;

  assign sat_next = (!first && sat_acc) || ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_acc <= 1'b0;
      src_sat <= 1'b0;
    end else begin
      if (acc_load) sat_acc <= sat_next;
      if (res_load) src_sat <= sat_next;
    end
  end
`else
  assign sum_next = sum_wrap;
  assign src_sat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      src_vld  <= 1'b0;
      src_data <= '0;
      src_cnt  <= '0;
    end else begin
      // A new result overrides the clear so accept+load has no bubble.
      if (res_load) begin
        src_vld  <= 1'b1;
        src_data <= sum_next;
        src_cnt  <= cnt_next;
        state    <= IDLE;
      end else if (src_vld && src_rdy) begin
        src_vld  <= 1'b0;
      end
      if (acc_load) begin
        acc   <= sum_next;
        cnt   <= cnt_next;
        state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed self-checking bench for dot_product_unit (ACC_W=16 build).
// Expected overflow result follows DPU_SATURATE_EN.
module tb_dot_product_unit;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                snk_vld;
  logic                snk_rdy;
  logic [2*DATA_W-1:0] snk_data;
  logic                snk_last;
  logic                src_vld;
  logic                src_rdy;
  logic [ACC_W-1:0]    src_data;
  logic [CNT_W-1:0]    src_cnt;
  logic                src_sat;
  logic                busy;

  int n_chk  = 0;
  int n_fail = 0;

  dot_product_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .snk_vld (snk_vld),
    .snk_rdy (snk_rdy),
    .snk_data(snk_data),
    .snk_last(snk_last),
    .src_vld (src_vld),
    .src_rdy (src_rdy),
    .src_data(src_data),
    .src_cnt (src_cnt),
    .src_sat (src_sat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*DATA_W-1:0] pack(input int w, input int x);
    logic [DATA_W-1:0] wb;
    logic [DATA_W-1:0] xb;
    wb = DATA_W'(w);
    xb = DATA_W'(x);
    return {xb, wb};
  endfunction

  // Offer one beat at a negedge, hold until accepted, drop just after.
  task automatic beat(input int w, input int x, input logic last);
    int n;
    @(negedge clk);
    snk_vld  = 1'b1;
    snk_data = pack(w, x);
    snk_last = last;
    n = 0;
    while (!snk_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("beat_timeout", 0, 1);
    @(posedge clk);
    #1 snk_vld = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int data,
                         input int cnt, input logic sat);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(src_vld), 1);
    chk({tag, "_data"}, $signed(src_data), data);
    chk({tag, "_cnt"}, 32'(src_cnt), cnt);
    chk({tag, "_sat"}, 32'(src_sat), 32'(sat));
  endtask

  initial begin
    rst      = 1'b1;
    snk_vld  = 1'b0;
    snk_data = '0;
    snk_last = 1'b0;
    src_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_snk_rdy", 32'(snk_rdy), 1);
      chk("rst_src_vld", 32'(src_vld), 0);
      chk("rst_src_data", $signed(src_data), 0);
      chk("rst_src_cnt", 32'(src_cnt), 0);
      chk("rst_src_sat", 32'(src_sat), 0);
      chk("rst_busy", 32'(busy), 0);
    end

    // Single row: 2 + 12 - 30 = -16
    beat(1, 2, 1'b0);
    beat(3, 4, 1'b0);
    @(negedge clk);
    chk("row_busy", 32'(busy), 1);
    chk("row_no_vld", 32'(src_vld), 0);
    beat(-5, 6, 1'b1);
    chk_res("row", -16, 3, 1'b0);
    chk("row_busy_end", 32'(busy), 0);
    @(negedge clk);
    chk("row_vld_drop", 32'(src_vld), 0);

    // Back-pressure
    src_rdy = 1'b0;
    beat(2, 5, 1'b1);
    chk_res("bp_first", 10, 1, 1'b0);
    snk_vld  = 1'b1;
    snk_data = pack(1, 1);
    snk_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_snk_rdy", 32'(snk_rdy), 0);
      chk("bp_hold_vld", 32'(src_vld), 1);
      chk("bp_hold_data", $signed(src_data), 10);
      @(negedge clk);
    end
    src_rdy = 1'b1;
    #1 chk("bp_release_rdy", 32'(snk_rdy), 1);
    @(posedge clk);
    #1 snk_vld = 1'b0;
    chk_res("bp_second", 1, 1, 1'b0);
    @(negedge clk);
    chk("bp_vld_drop", 32'(src_vld), 0);

    // Back-to-back single-beat rows
    snk_vld  = 1'b1;
    snk_data = pack(-128, -128);
    snk_last = 1'b1;
    @(posedge clk);
    chk_res("b2b_a", 16384, 1, 1'b0);
    snk_data = pack(127, -1);
    @(posedge clk);
    #1 snk_vld = 1'b0;
    chk_res("b2b_b", -127, 1, 1'b0);
    @(negedge clk);
    chk("b2b_vld_drop", 32'(src_vld), 0);

    // Overflow: 3 * 16129 = 48387 does not fit in 16 signed bits
    beat(127, 127, 1'b0);
    beat(127, 127, 1'b0);
    beat(127, 127, 1'b1);
`ifdef DPU_SATURATE_EN
    chk_res("ovf", 32767, 3, 1'b1);
`else
    chk_res("ovf", 48387 - 65536, 3, 1'b0);
`endif
    @(negedge clk);
    chk("ovf_vld_drop", 32'(src_vld), 0);

    // Reset mid-row
    beat(7, 7, 1'b0);
    beat(9, 9, 1'b0);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_vld", 32'(src_vld), 0);
    beat(2, 3, 1'b1);
    chk_res("mid_row", 6, 1, 1'b0);
    @(negedge clk);
    chk("mid_vld_drop", 32'(src_vld), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_single", 32'(src_vld), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
